// File: rtl/mcpu_alu_arbiter.sv
// mcpu_alu_arbiter: round-robin sharing of one ALU between two requesters with programmable operand settle time
module mcpu_alu_arbiter #(
  parameter int CMD_SIZE      = 3,
  parameter int WORD_SIZE     = 16,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0,
  input  logic [CMD_SIZE-1:0]  cmd0,
  input  logic [WORD_SIZE-1:0] a0,
  input  logic [WORD_SIZE-1:0] b0,
  output logic                 gnt0,
  output logic                 done0,
  input  logic                 req1,
  input  logic [CMD_SIZE-1:0]  cmd1,
  input  logic [WORD_SIZE-1:0] a1,
  input  logic [WORD_SIZE-1:0] b1,
  output logic                 gnt1,
  output logic                 done1,
  output logic [WORD_SIZE-1:0] result,
  output logic                 result_cf,
  output logic                 busy,
  output logic [CMD_SIZE-1:0]  alu_cmd,
  output logic [WORD_SIZE-1:0] alu_in1,
  output logic [WORD_SIZE-1:0] alu_in2,
  input  logic [WORD_SIZE-1:0] alu_out,
  input  logic                 alu_cf
);
  typedef enum logic {IDLE, SETTLE} state_t;
  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);
  state_t               state_q, state_d;
  logic [CMD_SIZE-1:0]  cmd_q, cmd_d;
  logic [WORD_SIZE-1:0] in1_q, in1_d, in2_q, in2_d, result_q, result_d;
  logic                 cf_q, cf_d, last_q, last_d, owner_q, owner_d;
  logic                 gnt0_q, gnt0_d, gnt1_q, gnt1_d, done0_q, done0_d, done1_q, done1_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 pick, carry_op;
  assign pick = req1 && (!req0 || !last_q);
  assign carry_op = cmd_q == CMD_SIZE'(3) || cmd_q == CMD_SIZE'(6) || cmd_q == CMD_SIZE'(7);
  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    in1_d    = in1_q;
    in2_d    = in2_q;
    result_d = result_q;
    cf_d     = cf_q;
    last_d   = last_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    gnt0_d   = 1'b0;
    gnt1_d   = 1'b0;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    if (state_q == IDLE) begin
      if (req0 || req1) begin
        cmd_d   = pick ? cmd1 : cmd0;
        in1_d   = pick ? a1 : a0;
        in2_d   = pick ? b1 : b0;
        owner_d = pick;
        last_d  = pick;
        cnt_d   = SETTLE_INIT;
        gnt0_d  = !pick;
        gnt1_d  = pick;
        state_d = SETTLE;
      end
    end else begin
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        result_d = alu_out;
        cf_d     = carry_op && alu_cf;
        done0_d  = !owner_q;
        done1_d  = owner_q;
        state_d  = IDLE;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cmd_q    <= '0;
      in1_q    <= '0;
      in2_q    <= '0;
      result_q <= '0;
      cf_q     <= 1'b0;
      last_q   <= 1'b1;
      owner_q  <= 1'b0;
      cnt_q    <= '0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      in1_q    <= in1_d;
      in2_q    <= in2_d;
      result_q <= result_d;
      cf_q     <= cf_d;
      last_q   <= last_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
    end
  end
  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign done0     = done0_q;
  assign done1     = done1_q;
  assign result    = result_q;
  assign result_cf = cf_q;
  assign busy      = state_q != IDLE;
  assign alu_cmd   = cmd_q;
  assign alu_in1   = in1_q;
  assign alu_in2   = in2_q;
endmodule

// File: tb/tb_mcpu_alu_arbiter.sv
// tb_mcpu_alu_arbiter: directed checks of the ALU arbiter with settle times 1 and 3
module tb_mcpu_alu_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  logic        req0, req1, gnt0, gnt1, done0, done1, rcf, busy, acf;
  logic [2:0]  cmd0, cmd1, acmd;
  logic [15:0] a0, b0, a1, b1, res, ain1, ain2, aout;
  logic        s_req0, s_gnt0, s_gnt1, s_done0, s_done1, s_rcf, s_busy, s_acf;
  logic [2:0]  s_cmd0, s_acmd;
  logic [15:0] s_a0, s_b0, s_res, s_ain1, s_ain2, s_aout;
  function automatic logic [16:0] alu(input logic [2:0] c, input logic [15:0] x, input logic [15:0] y);
    case (c)
      3'd0: alu = {1'b1, x & y};
      3'd1: alu = {1'b1, x | y};
      3'd2: alu = {1'b1, x ^ y};
      3'd4: alu = {1'b1, x << y[3:0]};
      3'd5: alu = {1'b1, x >> y[3:0]};
      3'd6: alu = {1'b0, x} - {1'b0, y};
      default: alu = {1'b0, x} + {1'b0, y};
    endcase
  endfunction
  assign {acf, aout}     = alu(acmd, ain1, ain2);
  assign {s_acf, s_aout} = alu(s_acmd, s_ain1, s_ain2);
  mcpu_alu_arbiter #(.CMD_SIZE(3), .WORD_SIZE(16), .SETTLE_CYCLES(1)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .cmd0(cmd0), .a0(a0), .b0(b0), .gnt0(gnt0), .done0(done0),
    .req1(req1), .cmd1(cmd1), .a1(a1), .b1(b1), .gnt1(gnt1), .done1(done1),
    .result(res), .result_cf(rcf), .busy(busy),
    .alu_cmd(acmd), .alu_in1(ain1), .alu_in2(ain2), .alu_out(aout), .alu_cf(acf)
  );
  mcpu_alu_arbiter #(.CMD_SIZE(3), .WORD_SIZE(16), .SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst),
    .req0(s_req0), .cmd0(s_cmd0), .a0(s_a0), .b0(s_b0), .gnt0(s_gnt0), .done0(s_done0),
    .req1(1'b0), .cmd1(3'd0), .a1(16'd0), .b1(16'd0), .gnt1(s_gnt1), .done1(s_done1),
    .result(s_res), .result_cf(s_rcf), .busy(s_busy),
    .alu_cmd(s_acmd), .alu_in1(s_ain1), .alu_in2(s_ain2), .alu_out(s_aout), .alu_cf(s_acf)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic set0(input logic r, input logic [2:0] c, input logic [15:0] x, input logic [15:0] y);
    req0 = r; cmd0 = c; a0 = x; b0 = y;
  endtask
  task automatic set1(input logic r, input logic [2:0] c, input logic [15:0] x, input logic [15:0] y);
    req1 = r; cmd1 = c; a1 = x; b1 = y;
  endtask
  task automatic pulse_rst();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask
  initial begin
    set0(0, 0, 0, 0);
    set1(0, 0, 0, 0);
    s_req0 = 0; s_cmd0 = 0; s_a0 = 0; s_b0 = 0;
    step();
    step();
    chk("rst_outs", {gnt0, gnt1, done0, done1, rcf, busy}, 0);
    chk("rst_res", res, 0);
    chk("rst_alu", {acmd, ain1, ain2}, 0);
    rst = 1'b0;
    step();
    chk("idle_busy", busy, 0);
    set0(1, 3, 16'hFFFF, 16'h0001);
    step();
    chk("t1_gnt", {gnt0, gnt1, done0, done1, busy}, 5'b10001);
    chk("t1_alu", {acmd, ain1, ain2}, {3'd3, 16'hFFFF, 16'h0001});
    set0(0, 0, 0, 0);
    step();
    chk("t1_done", {gnt0, gnt1, done0, done1, busy}, 5'b00100);
    chk("t1_res", {rcf, res}, {1'b1, 16'h0000});
    step();
    chk("t1_quiet", {gnt0, gnt1, done0, done1, busy}, 0);
    pulse_rst();
    set0(1, 6, 16'h0003, 16'h0005);
    set1(1, 1, 16'h00F0, 16'h0F00);
    step();
    chk("t2_gnt0", {gnt0, gnt1}, 2'b10);
    set0(0, 0, 0, 0);
    step();
    chk("t2_done0", {done0, done1}, 2'b10);
    chk("t2_res0", {rcf, res}, {1'b1, 16'hFFFE});
    step();
    chk("t2_gnt1", {gnt0, gnt1}, 2'b01);
    set1(0, 0, 0, 0);
    step();
    chk("t2_done1", {done0, done1}, 2'b01);
    chk("t2_res1", {rcf, res}, {1'b0, 16'h0FF0});
    set0(1, 3, 16'd1, 16'd2);
    set1(1, 3, 16'd10, 16'd20);
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("t3_gnt%0d", i), {gnt0, gnt1}, (i % 2 == 0) ? 2'b10 : 2'b01);
      step();
      chk($sformatf("t3_done%0d", i), {done0, done1, gnt0, gnt1}, (i % 2 == 0) ? 4'b1000 : 4'b0100);
      chk($sformatf("t3_res%0d", i), res, (i % 2 == 0) ? 16'd3 : 16'd30);
    end
    set0(0, 0, 0, 0);
    set1(0, 0, 0, 0);
    step();
    set0(1, 3, 16'h8000, 16'h8000);
    step();
    set0(0, 0, 0, 0);
    step();
    chk("t4_add", {done0, rcf, res}, {2'b11, 16'h0000});
    set0(1, 0, 16'hFFFF, 16'h00FF);
    step();
    set0(0, 0, 0, 0);
    step();
    chk("t4_and", {done0, rcf, res}, {2'b10, 16'h00FF});
    set0(1, 2, 16'h1234, 16'h0001);
    step();
    chk("t6_gnt", {gnt0, busy}, 2'b11);
    set0(0, 0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_async", {gnt0, gnt1, done0, done1, busy, rcf}, 0);
    chk("t6_regs", {res, acmd, ain1, ain2}, 0);
    step();
    rst = 1'b0;
    step();
    chk("t6_nodone", {done0, done1, busy}, 0);
    set0(1, 1, 16'h0001, 16'h0002);
    set1(1, 1, 16'h0004, 16'h0008);
    step();
    chk("t6_last", {gnt0, gnt1}, 2'b10);
    set0(0, 0, 0, 0);
    set1(0, 0, 0, 0);
    step();
    chk("t6_res", {done0, res}, {1'b1, 16'h0003});
    s_req0 = 1; s_cmd0 = 4; s_a0 = 16'h0001; s_b0 = 16'h0004;
    step();
    chk("t5_gnt", {s_gnt0, s_busy}, 2'b11);
    s_req0 = 0; s_cmd0 = 0; s_a0 = 16'hAAAA; s_b0 = 16'h5555;
    for (int i = 1; i < 3; i++) begin
      step();
      chk($sformatf("t5_hold%0d", i), {s_busy, s_done0, s_gnt0, s_ain1, s_ain2}, {3'b100, 16'h0001, 16'h0004});
    end
    step();
    chk("t5_done", {s_done0, s_busy, s_done1}, 3'b100);
    chk("t5_res", {s_rcf, s_res}, {1'b0, 16'h0010});
    step();
    chk("t5_quiet", {s_done0, s_busy}, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
